frog_move_decoder: RTL



---
 rtl/frog_move_decoder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/frog_move_decoder.sv
// frog_move_decoder: per-frame WASD/arrow keycode decoder with hold-to-repeat and a hop FIFO
// Optional feature macro FROG_AUTOREPEAT_EN: when defined, held keys auto-repeat after
// REPEAT_DELAY ticks and then every REPEAT_RATE ticks; otherwise one hop per press.
module frog_move_decoder #(
  parameter int REPEAT_DELAY = 20,
  parameter int REPEAT_RATE  = 6,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          frame_clk,
  input  logic [15:0]                   keycode,
  input  logic                          move_ready,
  output logic                          move_valid,
  output logic [1:0]                    move_dir,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  if (REPEAT_DELAY < 1 || REPEAT_RATE < 1 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("frog_move_decoder: illegal parameter value");
  end
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
  state_t        state_q, state_d;
  logic [1:0]    held_q, held_d;
  logic          s1_q, s2_q, s3_q, tick_q;
  logic [1:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic [1:0]    last_q;
  logic          ovf_q;
  logic          k0_ok, k1_ok, key_ok;
  logic [1:0]    k0_dir, k1_dir, key_dir;
  logic          push, pop, full, wr_en;
`ifdef FROG_AUTOREPEAT_EN
  localparam int CW = $clog2((REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1);
  logic [CW-1:0] rc_q, rc_d;
`endif

  function automatic logic [2:0] decode(input logic [7:0] k);
    case (k)
      8'h1A, 8'h52: decode = 3'b100;
      8'h16, 8'h51: decode = 3'b101;
      8'h04, 8'h50: decode = 3'b110;
      8'h07, 8'h4F: decode = 3'b111;
      default:      decode = 3'b000;
    endcase
  endfunction

  assign {k0_ok, k0_dir} = decode(keycode[7:0]);
  assign {k1_ok, k1_dir} = decode(keycode[15:8]);
  assign key_ok     = k0_ok | k1_ok;
  assign key_dir    = k0_ok ? k0_dir : k1_dir;
  assign move_valid = cnt_q != '0;
  assign move_dir   = move_valid ? mem_q[rd_q] : last_q;
  assign fifo_count = cnt_q;
  assign overflow   = ovf_q;
  assign full       = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign pop        = move_valid & move_ready;
  assign wr_en      = push & (~full | pop);
  assign cnt_d      = cnt_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};

  // Hop FSM: decides on each frame tick whether the held key produces a hop
  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    push    = 1'b0;
`ifdef FROG_AUTOREPEAT_EN
    rc_d    = rc_q;
`endif
    if (tick_q) begin
      if (!key_ok) state_d = IDLE;
      else if (state_q == IDLE || key_dir != held_q) begin
        push    = 1'b1;
        held_d  = key_dir;
        state_d = DELAY;
`ifdef FROG_AUTOREPEAT_EN
        rc_d    = CW'(REPEAT_DELAY - 1);
`endif
      end
`ifdef FROG_AUTOREPEAT_EN
      else if (rc_q != '0) rc_d = rc_q - 1'b1;
      else begin
        push    = 1'b1;
        rc_d    = CW'(REPEAT_RATE - 1);
        state_d = REPEAT;
      end
`endif
    end
  end

  // All state: frame_clk synchroniser, FSM registers and hop FIFO
  always_ff @(posedge Clk) begin
    if (Reset) begin
      {s1_q, s2_q, s3_q, tick_q} <= '0;
      state_q <= IDLE;
      held_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
      ovf_q   <= 1'b0;
`ifdef FROG_AUTOREPEAT_EN
      rc_q    <= '0;
`endif
    end else begin
      s1_q    <= frame_clk;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      tick_q  <= s2_q & ~s3_q;
      state_q <= state_d;
      held_q  <= held_d;
      cnt_q   <= cnt_d;
`ifdef FROG_AUTOREPEAT_EN
      rc_q    <= rc_d;
`endif
      if (wr_en) begin
        mem_q[wr_q] <= key_dir;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) begin
        last_q <= mem_q[rd_q];
        rd_q   <= rd_q + 1'b1;
      end
      if (push && full && !pop) ovf_q <= 1'b1;
    end
  end
endmodule
